// File: rtl/muldiv_arbiter_if.sv
// rtl/muldiv_arbiter_if.sv - request, response and MDU-side signal bundle for muldiv_arbiter
interface muldiv_arbiter_if #(
  parameter int TAG_W = 5
);
  logic             req0_valid_i;
  logic             req0_ready_o;
  logic [2:0]       req0_op_i;
  logic [31:0]      req0_num1_i;
  logic [31:0]      req0_num2_i;
  logic [TAG_W-1:0] req0_tag_i;
  logic             req1_valid_i;
  logic             req1_ready_o;
  logic [2:0]       req1_op_i;
  logic [31:0]      req1_num1_i;
  logic [31:0]      req1_num2_i;
  logic [TAG_W-1:0] req1_tag_i;
  logic [1:0]       flush_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic             resp_id_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic [31:0]      resp_result_o;
  logic             mdu_valid_o;
  logic [2:0]       mdu_op_o;
  logic [31:0]      mdu_num1_o;
  logic [31:0]      mdu_num2_o;
  logic             mdu_busy_i;
  logic [31:0]      mdu_result_i;

  // The arbiter is the slave of both requesters and drives the MDU.
  modport slave (
    input  req0_valid_i, req0_op_i, req0_num1_i, req0_num2_i, req0_tag_i,
    input  req1_valid_i, req1_op_i, req1_num1_i, req1_num2_i, req1_tag_i,
    input  flush_i, resp_ready_i, mdu_busy_i, mdu_result_i,
    output req0_ready_o, req1_ready_o, resp_valid_o, resp_id_o, resp_tag_o, resp_result_o,
    output mdu_valid_o, mdu_op_o, mdu_num1_o, mdu_num2_o
  );

  modport master (
    output req0_valid_i, req0_op_i, req0_num1_i, req0_num2_i, req0_tag_i,
    output req1_valid_i, req1_op_i, req1_num1_i, req1_num2_i, req1_tag_i,
    output flush_i, resp_ready_i, mdu_busy_i, mdu_result_i,
    input  req0_ready_o, req1_ready_o, resp_valid_o, resp_id_o, resp_tag_o, resp_result_o,
    input  mdu_valid_o, mdu_op_o, mdu_num1_o, mdu_num2_o
  );
endinterface

// File: rtl/muldiv_arbiter.sv
// rtl/muldiv_arbiter.sv - round-robin sharing of one multi-cycle MDU between two requesters
module muldiv_arbiter #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  muldiv_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             discard_q, discard_d;
  logic             first_q, first_d;
  logic             id_q, id_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      num1_q, num1_d;
  logic [31:0]      num2_q, num2_d;
  logic [31:0]      result_q, result_d;

  logic v0, v1, grant1, ready0, ready1, own_flush, complete;

  always_comb begin
    v0        = bus.req0_valid_i && !bus.flush_i[0];
    v1        = bus.req1_valid_i && !bus.flush_i[1];
    grant1    = v1 && (!v0 || prio_q);
    ready0    = (state_q == IDLE) && v0 && !grant1;
    ready1    = (state_q == IDLE) && grant1;
    own_flush = bus.flush_i[id_q];
    // The MDU echoes input_valid as busy on the entry cycle, so that cycle cannot complete.
    complete  = (state_q == ISSUE) && !first_q && !bus.mdu_busy_i;

    state_d   = state_q;
    prio_d    = prio_q;
    discard_d = discard_q;
    first_d   = first_q;
    id_d      = id_q;
    tag_d     = tag_q;
    op_d      = op_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (ready0 || ready1) begin
          id_d      = grant1;
          op_d      = grant1 ? bus.req1_op_i   : bus.req0_op_i;
          num1_d    = grant1 ? bus.req1_num1_i : bus.req0_num1_i;
          num2_d    = grant1 ? bus.req1_num2_i : bus.req0_num2_i;
          tag_d     = grant1 ? bus.req1_tag_i  : bus.req0_tag_i;
          prio_d    = !grant1;
          discard_d = 1'b0;
          first_d   = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        first_d = 1'b0;
        if (own_flush) discard_d = 1'b1;
        if (complete) begin
          if (discard_q || own_flush) begin
            state_d = IDLE;
          end else begin
            result_d = bus.mdu_result_i;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (own_flush || bus.resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      discard_q <= 1'b0;
      first_q   <= 1'b0;
      id_q      <= 1'b0;
      tag_q     <= '0;
      op_q      <= '0;
      num1_q    <= '0;
      num2_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      discard_q <= discard_d;
      first_q   <= first_d;
      id_q      <= id_d;
      tag_q     <= tag_d;
      op_q      <= op_d;
      num1_q    <= num1_d;
      num2_q    <= num2_d;
      result_q  <= result_d;
    end
  end

  assign bus.req0_ready_o  = ready0;
  assign bus.req1_ready_o  = ready1;
  assign bus.resp_valid_o  = (state_q == RESP) && !own_flush;
  assign bus.resp_id_o     = id_q;
  assign bus.resp_tag_o    = tag_q;
  assign bus.resp_result_o = result_q;
  assign bus.mdu_valid_o   = (state_q == ISSUE);
  assign bus.mdu_op_o      = op_q;
  assign bus.mdu_num1_o    = num1_q;
  assign bus.mdu_num2_o    = num2_q;
endmodule

// File: tb/tb_muldiv_arbiter.sv
// tb/tb_muldiv_arbiter.sv - directed bench for muldiv_arbiter with a behavioural MDU and response scoreboard
module tb_muldiv_arbiter;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  muldiv_arbiter_if #(.TAG_W(TAG_W)) bus();
  muldiv_arbiter #(.TAG_W(TAG_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct packed {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
  } exp_t;

  exp_t sbq[$];
  int   grants[$];
  int   checks = 0, errors = 0, hs_count = 0, rdy0_cnt = 0, rdy1_cnt = 0;

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    p  = '0;
    case (op)
      3'd0: p = {32'b0, a * b};
      3'd1: p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
      3'd2: p = 64'($signed({{32{a[31]}}, a}) * $signed({32'b0, b}));
      3'd3: p = {32'b0, a} * {32'b0, b};
      default: p = '0;
    endcase
    case (op)
      3'd0:    return p[31:0];
      3'd4:    return (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
      3'd5:    return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6:    return (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(sa % sb);
      3'd7:    return (b == 0) ? a : a % b;
      default: return p[63:32];
    endcase
  endfunction

  // MDU model: busy echoes input_valid from idle, MUL takes 5 busy cycles, DIV 10.
  logic [3:0] mdu_cnt_q;
  logic       mdu_hold_q;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mdu_cnt_q  <= '0;
      mdu_hold_q <= 1'b0;
    end else if (mdu_cnt_q != 0) begin
      mdu_cnt_q <= mdu_cnt_q - 4'd1;
      if (mdu_cnt_q == 4'd1) mdu_hold_q <= 1'b1;
    end else if (!bus.mdu_valid_o) begin
      mdu_hold_q <= 1'b0;
    end else if (!mdu_hold_q) begin
      mdu_cnt_q <= bus.mdu_op_o[2] ? 4'd9 : 4'd4;
    end
  end
  assign bus.mdu_busy_i   = (mdu_cnt_q != 0) || (bus.mdu_valid_o && !mdu_hold_q);
  assign bus.mdu_result_i = mdu_hold_q ? ref_res(bus.mdu_op_o, bus.mdu_num1_o, bus.mdu_num2_o) : 32'hDEADBEEF;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.req0_ready_o) rdy0_cnt++;
      if (bus.req1_ready_o) rdy1_cnt++;
      if (bus.req0_valid_i && bus.req0_ready_o) begin
        sbq.push_back({1'b0, bus.req0_tag_i, ref_res(bus.req0_op_i, bus.req0_num1_i, bus.req0_num2_i)});
        grants.push_back(0);
      end
      if (bus.req1_valid_i && bus.req1_ready_o) begin
        sbq.push_back({1'b1, bus.req1_tag_i, ref_res(bus.req1_op_i, bus.req1_num1_i, bus.req1_num2_i)});
        grants.push_back(1);
      end
      if (bus.resp_valid_o && bus.resp_ready_i) begin
        exp_t e;
        hs_count++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected observed tag=%0h expected no response", bus.resp_tag_o);
        end else begin
          e = sbq.pop_front();
          chk("sb_id", 64'(bus.resp_id_o), 64'(e.id));
          chk("sb_tag", 64'(bus.resp_tag_o), 64'(e.tag));
          chk("sb_result", 64'(bus.resp_result_o), 64'(e.res));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t);
    if (n == 0) begin
      bus.req0_valid_i = v; bus.req0_op_i = op; bus.req0_num1_i = a; bus.req0_num2_i = b; bus.req0_tag_i = t;
    end else begin
      bus.req1_valid_i = v; bus.req1_op_i = op; bus.req1_num1_i = a; bus.req1_num2_i = b; bus.req1_tag_i = t;
    end
  endtask

  // which: 0 req0_ready, 1 req1_ready, 2 resp_valid
  task automatic wait_sig(input string name, input int which, input int bound);
    bit hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      sample();
      hit = (which == 0) ? bus.req0_ready_o : (which == 1) ? bus.req1_ready_o : bus.resp_valid_o;
    end
    if (!hit) begin
      checks++;
      errors++;
      $error("FAIL %s observed timeout after %0d cycles expected event", name, bound);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      if (sbq.size() == 0 && !bus.resp_valid_o && !bus.mdu_valid_o) break;
      sample();
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_ready0"}, 64'(bus.req0_ready_o), 64'd0);
    chk({pfx, "_ready1"}, 64'(bus.req1_ready_o), 64'd0);
    chk({pfx, "_resp_valid"}, 64'(bus.resp_valid_o), 64'd0);
    chk({pfx, "_resp_id"}, 64'(bus.resp_id_o), 64'd0);
    chk({pfx, "_resp_tag"}, 64'(bus.resp_tag_o), 64'd0);
    chk({pfx, "_resp_result"}, 64'(bus.resp_result_o), 64'd0);
    chk({pfx, "_mdu_valid"}, 64'(bus.mdu_valid_o), 64'd0);
    chk({pfx, "_mdu_op"}, 64'(bus.mdu_op_o), 64'd0);
    chk({pfx, "_mdu_num1"}, 64'(bus.mdu_num1_o), 64'd0);
    chk({pfx, "_mdu_num2"}, 64'(bus.mdu_num2_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, lat, h;
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0, '0);
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0, '0);
    bus.flush_i      = 2'b00;
    bus.resp_ready_i = 1'b0;
    #13;
    chk_all_zero("reset");
    tick();
    rstn = 1'b1;

    // Single MUL with exact latency
    tick();
    bus.resp_ready_i = 1'b1;
    set_req(0, 1'b1, 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
    sample();
    chk("mul_ready0", 64'(bus.req0_ready_o), 64'd1);
    chk("mul_ready1", 64'(bus.req1_ready_o), 64'd0);
    tick();
    bus.req0_valid_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      sample();
      chk($sformatf("mul_mdu_valid_c%0d", k), 64'(bus.mdu_valid_o), 64'd1);
      chk($sformatf("mul_mdu_num2_c%0d", k), 64'(bus.mdu_num2_o), 64'hFFFFFFFD);
      chk($sformatf("mul_resp_valid_c%0d", k), 64'(bus.resp_valid_o), 64'd0);
    end
    sample();
    chk("mul_resp_valid_c7", 64'(bus.resp_valid_o), 64'd1);
    chk("mul_mdu_valid_c7", 64'(bus.mdu_valid_o), 64'd0);
    chk("mul_resp_id", 64'(bus.resp_id_o), 64'd0);
    chk("mul_resp_tag", 64'(bus.resp_tag_o), 64'd5);
    chk("mul_resp_result", 64'(bus.resp_result_o), 64'hFFFFFFEB);
    drain();

    // Contention from reset priority
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    grants.delete();
    rdy0_cnt = 0;
    rdy1_cnt = 0;
    set_req(0, 1'b1, 3'd0, 32'd3, 32'd4, 5'd3);
    set_req(1, 1'b1, 3'd3, 32'hFFFFFFFF, 32'd2, 5'd17);
    for (int i = 0; i < 100 && grants.size() < 4; i++) sample();
    tick();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    chk("cont_grants", 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      n = (i < grants.size()) ? grants[i] : -1;
      chk($sformatf("cont_grant%0d", i), 64'(n), 64'(i % 2));
    end
    chk("cont_rdy0_pulses", 64'(rdy0_cnt), 64'd2);
    chk("cont_rdy1_pulses", 64'(rdy1_cnt), 64'd2);
    drain();

    // Response backpressure; a flush of the other requester is ignored
    tick();
    bus.resp_ready_i = 1'b0;
    set_req(0, 1'b1, 3'd0, 32'h1234, 32'h10, 5'd9);
    set_req(1, 1'b1, 3'd0, 32'd5, 32'd5, 5'd11);
    wait_sig("bp_accept0", 0, 20);
    tick();
    bus.req0_valid_i = 1'b0;
    wait_sig("bp_resp", 2, 20);
    for (int k = 0; k < 10; k++) begin
      tick();
      bus.flush_i = (k == 4) ? 2'b10 : 2'b00;
      sample();
      chk("bp_resp_valid", 64'(bus.resp_valid_o), 64'd1);
      chk("bp_resp_result", 64'(bus.resp_result_o), 64'h12340);
      chk("bp_resp_tag", 64'(bus.resp_tag_o), 64'd9);
      chk("bp_no_grant1", 64'(bus.req1_ready_o), 64'd0);
    end
    tick();
    bus.flush_i      = 2'b00;
    bus.resp_ready_i = 1'b1;
    sample();
    chk("bp_release_valid", 64'(bus.resp_valid_o), 64'd1);
    sample();
    chk("bp_next_grant1", 64'(bus.req1_ready_o), 64'd1);
    tick();
    bus.req1_valid_i = 1'b0;
    drain();

    // Flush of an in-flight DIVU; pending req0 granted right after completion
    tick();
    set_req(1, 1'b1, 3'd5, 32'd100, 32'd7, 5'd4);
    wait_sig("fl_accept1", 1, 20);
    tick();
    bus.req1_valid_i = 1'b0;
    set_req(0, 1'b1, 3'd2, 32'hFFFFFFFB, 32'd3, 5'd6);
    sample();
    chk("fl_mdu_valid_c1", 64'(bus.mdu_valid_o), 64'd1);
    tick();
    bus.flush_i = 2'b10;
    void'(sbq.pop_back());
    sample();
    chk("fl_mdu_valid_c2", 64'(bus.mdu_valid_o), 64'd1);
    tick();
    bus.flush_i = 2'b00;
    n = 2;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (!bus.mdu_valid_o) break;
      n++;
      chk("fl_no_resp", 64'(bus.resp_valid_o), 64'd0);
    end
    chk("fl_issue_cycles", 64'(n), 64'd11);
    chk("fl_idle_grant0", 64'(bus.req0_ready_o), 64'd1);
    chk("fl_idle_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    tick();
    bus.req0_valid_i = 1'b0;
    drain();

    // Flush in RESP coinciding with resp_ready
    tick();
    bus.resp_ready_i = 1'b0;
    set_req(0, 1'b1, 3'd1, 32'h80000000, 32'h80000000, 5'd7);
    wait_sig("fr_accept0", 0, 20);
    tick();
    bus.req0_valid_i = 1'b0;
    wait_sig("fr_resp", 2, 20);
    h = hs_count;
    tick();
    bus.flush_i      = 2'b01;
    bus.resp_ready_i = 1'b1;
    void'(sbq.pop_front());
    #1;
    chk("fr_valid_dropped", 64'(bus.resp_valid_o), 64'd0);
    tick();
    bus.flush_i = 2'b00;
    set_req(1, 1'b1, 3'd0, 32'd2, 32'd3, 5'd1);
    sample();
    chk("fr_valid_after", 64'(bus.resp_valid_o), 64'd0);
    chk("fr_idle_grant1", 64'(bus.req1_ready_o), 64'd1);
    chk("fr_no_handshake", 64'(hs_count), 64'(h));
    tick();
    bus.req1_valid_i = 1'b0;
    drain();

    // Asynchronous reset mid-DIV, then a normal MUL
    tick();
    set_req(1, 1'b1, 3'd4, 32'hFFFFFF9C, 32'd7, 5'd2);
    wait_sig("ar_accept1", 1, 20);
    tick();
    bus.req1_valid_i = 1'b0;
    sample();
    sample();
    sample();
    chk("ar_in_issue", 64'(bus.mdu_valid_o), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("areset");
    sbq.delete();
    tick();
    rstn = 1'b1;
    set_req(0, 1'b1, 3'd0, 32'd9, 32'd9, 5'd12);
    sample();
    chk("ar_ready0", 64'(bus.req0_ready_o), 64'd1);
    tick();
    bus.req0_valid_i = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      lat++;
      if (bus.resp_valid_o) break;
    end
    chk("ar_mul_latency", 64'(lat), 64'd7);
    chk("ar_mul_result", 64'(bus.resp_result_o), 64'd81);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_arbiter.md
# muldiv_arbiter

Shares the single multi-cycle multiply/divide unit (MDU) between two requesters, e.g. the integer pipe and a second issue port. Grants requests round-robin, latches the winning operands and holds them stable on the MDU for the whole operation. Detects completion from the MDU busy flag and returns the result, with requester id and tag, on a held response channel. Flushed operations are allowed to finish inside the MDU, and their results are discarded.

## Interface
Parameters:
- TAG_W, default 5: width of the requester-supplied tag returned with the result.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req0_valid_i / req1_valid_i  in  1  request present.
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle when valid && ready.
- req0_op_i / req1_op_i  in  3  MDU op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req0_num1_i, req0_num2_i / req1_num1_i, req1_num2_i  in  32  operands.
- req0_tag_i / req1_tag_i  in  TAG_W  opaque tag.
- flush_i  in  2  bit n cancels everything owned by requester n.
- resp_valid_o  out  1  result available.
- resp_ready_i  in  1  consumer accepts the result.
- resp_id_o  out  1  owning requester.
- resp_tag_o  out  TAG_W  tag of the owning request.
- resp_result_o  out  32  MDU result.
- mdu_valid_o  out  1  drives MDU input_valid.
- mdu_op_o  out  3  drives the MDU op.
- mdu_num1_o, mdu_num2_o  out  32  drive the MDU operands.
- mdu_busy_i  in  1  MDU busy.
- mdu_result_i  in  32  MDU result; combinational, valid in the completion cycle.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP.
- Grant in IDLE:
  - If exactly one requester is valid and not flushed, that requester wins.
  - If both are, the requester pointed to by the 1-bit priority pointer `prio` wins.
  - reqN_ready_o = (state==IDLE) && grant==N && !flush_i[N]. The ready for a requester is never asserted outside IDLE.
- On acceptance:
  - Latch op, num1, num2, tag and id into the issue register.
  - Set prio to the other requester.
  - Clear the discard flag.
  - Go to ISSUE.
- ISSUE:
  - mdu_valid_o=1. mdu_op/num1/num2 come from the issue register and are constant for the whole state.
  - Completion is the first ISSUE cycle after the first with mdu_busy_i==0. The entry cycle is ignored, because the MDU reports busy=input_valid from idle.
  - At completion, capture mdu_result_i into resp_result.
  - If the discard flag is clear, go to RESP; if set, go to IDLE.
  - mdu_valid_o must be 0 in the cycle after completion, so the MDU does not restart.
- RESP:
  - resp_valid_o=1; resp_id, tag and result are held stable.
  - When resp_ready_i=1, go to IDLE.
- Flush:
  - flush_i[id]=1 in ISSUE sets the discard flag. The MDU is not aborted; the operation runs to completion and its result is dropped.
  - flush_i[id]=1 in RESP drops resp_valid_o and moves to IDLE next cycle, even if resp_ready_i is also high that cycle.
  - A flush targeting the other requester has no effect.
- Result rules: the result is passed through unmodified. Divide-by-zero and sign handling are owned by the MDU.

## Timing
- Reset values: state=IDLE, prio=0, discard=0. All outputs are 0: both readies, resp_valid_o, resp_id_o, resp_tag_o, resp_result_o, mdu_valid_o, mdu_op_o, mdu_num1_o and mdu_num2_o.
- Reset asserted mid-operation returns to IDLE immediately. The MDU shares the same reset.
- MUL-class latency: accept at cycle 0; ISSUE covers cycles 1–6, with completion at 6 (the MDU's 5-stage DSP path); resp_valid_o rises at cycle 7.
- DIV-class latency: 1 + the divider latency + 1 cycles. The arbiter makes no assumption about divider latency.
- Throughput:
  - At most one operation is in flight.
  - The earliest next acceptance is the cycle after leaving RESP, or the cycle after completion when the result is discarded.
  - With resp_ready_i tied high, a MUL stream sustains 1 operation per 8 cycles.
- Requests are held by the requester until accepted; the arbiter ignores changes on unaccepted requests.

## Test plan
- Single MUL: req0 op=000, num1=7, num2=-3, tag=5 → ready at cycle 0; mdu_valid_o high cycles 1–6; resp at cycle 7 with id=0, tag=5, result=0xFFFFFFEB.
- Contention: both requesters valid continuously, prio=0 at reset → grants alternate 0,1,0,1. Each reqN_ready_o pulses exactly once per grant.
- Response backpressure: resp_ready_i held low for 10 cycles → resp_valid_o, resp_result_o and resp_tag_o stable throughout; no new grant; accepted when resp_ready_i=1.
- Flush mid-ISSUE: req1 DIVU 100/7 accepted, flush_i=2'b10 two cycles later → mdu_valid_o stays high until MDU completion; no resp_valid_o; IDLE next cycle; a pending req0 is granted immediately after.
- Flush in RESP together with resp_ready_i=1 → resp_valid_o drops, with no handshake counted.
- Async reset during ISSUE: rstn low mid-DIV → all outputs 0 without a clock edge; after release, a new MUL completes with the normal 7-cycle latency.
